// File: rtl/pcseq_pkg.sv
// Shared types and constants for the pc_sequencer control-flow block.
package pcseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } pcseq_state_e;

    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_OVF  = 2'd1,
        FC_UNF  = 2'd2,
        FC_ILL  = 2'd3
    } pcseq_fault_e;

    // One-hot PC command; the encoding itself keeps jmp/call/ret exclusive.
    typedef enum logic [2:0] {
        CMD_NONE = 3'b000,
        CMD_JMP  = 3'b001,
        CMD_CALL = 3'b010,
        CMD_RET  = 3'b100
    } pcseq_cmd_e;

    localparam logic [15:0] PCSEQ_IRQ_VECTOR = 16'h0004;

    function automatic logic onehot3(input logic a, input logic b, input logic c);
        return (a ^ b ^ c) & ~(a & b & c);
    endfunction

endpackage

// File: rtl/pcseq_depth_tracker.sv
// Saturating call-stack depth mirror: up/down counter with clear, full and empty flags.
module pcseq_depth_tracker #(
    parameter int unsigned DEPTH_W     = 10,
    parameter int unsigned STACK_DEPTH = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    output logic [DEPTH_W:0] depth,
    output logic             full,
    output logic             empty
);

    localparam logic [DEPTH_W:0] FULL_VAL = (DEPTH_W + 1)'(STACK_DEPTH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            depth <= '0;
        end else if (clear) begin
            depth <= '0;
        end else if (inc && !dec && !full) begin
            depth <= depth + 1'b1;
        end else if (dec && !inc && !empty) begin
            depth <= depth - 1'b1;
        end
    end

    assign full  = (depth >= FULL_VAL);
    assign empty = (depth == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Control-flow sequencer ahead of the PC: init, halt, fault and redirect arbitration.
// Interrupt entry and in_irq tracking exist only when PCSEQ_IRQ_EN is defined.
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       STACK_DEPTH = 1024,
    parameter int unsigned       DEPTH_W     = 10,
    parameter int unsigned       INIT_CYCLES = 4,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR  = ADDR_W'(PCSEQ_IRQ_VECTOR)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              clr_fault,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic              dec_jmp,
    input  logic              dec_call,
    input  logic              dec_ret,
    input  logic [ADDR_W-1:0] dec_target,
    input  logic              irq_req,
    output logic              irq_ack,
    output logic              pc_init_flag,
    output logic              pc_jmp_flag,
    output logic              pc_call_flag,
    output logic              pc_ret_flag,
    output logic [ADDR_W-1:0] pc_target,
    output logic [DEPTH_W:0]  stack_depth,
    output logic              in_irq,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int unsigned    CNT_W     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES - 1);

    pcseq_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    pcseq_cmd_e        cmd_q, cmd_d;
    pcseq_fault_e      code_q, code_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              init_q, fault_q, ack_q, ack_d;

    logic              depth_inc, depth_dec, depth_clr;
    logic              depth_full, depth_empty;
    logic [DEPTH_W:0]  depth;

    logic in_run, kind_ok, irq_take, ready_c, dec_fire;
    logic do_jmp, do_call, do_ret;
    logic fault_ovf, fault_unf, fault_ill, any_fault, fault_clear;

    pcseq_depth_tracker #(
        .DEPTH_W     (DEPTH_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_depth (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (depth_inc),
        .dec     (depth_dec),
        .clear   (depth_clr),
        .depth   (depth),
        .full    (depth_full),
        .empty   (depth_empty)
    );

`ifdef PCSEQ_IRQ_EN
    logic             in_irq_q, in_irq_d;
    logic [DEPTH_W:0] saved_q, saved_d, depth_dn;

    assign irq_take = in_run & ~halt_req & irq_req & ~in_irq_q & ~depth_full;
    assign depth_dn = depth - 1'b1;

    // Interrupt ends on the ret that brings depth back to its value at entry.
    always_comb begin
        in_irq_d = in_irq_q;
        saved_d  = saved_q;
        if (irq_take) begin
            in_irq_d = 1'b1;
            saved_d  = depth;
        end else if (do_ret && in_irq_q && (depth_dn == saved_q)) begin
            in_irq_d = 1'b0;
        end
        if (fault_clear) begin
            in_irq_d = 1'b0;
            saved_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_irq_q <= 1'b0;
            saved_q  <= '0;
        end else begin
            in_irq_q <= in_irq_d;
            saved_q  <= saved_d;
        end
    end

    assign in_irq = in_irq_q;
`else
    logic              irq_unused;
    logic [ADDR_W-1:0] irq_vector_unused;

    assign irq_unused        = irq_req;
    assign irq_vector_unused = IRQ_VECTOR;
    assign irq_take          = 1'b0;
    assign in_irq            = 1'b0;
`endif

    assign in_run      = (state_q == ST_RUN);
    assign kind_ok     = onehot3(dec_jmp, dec_call, dec_ret);
    assign ready_c     = in_run & ~halt_req & ~irq_take;
    assign dec_fire    = ready_c & dec_valid;
    assign fault_ill   = dec_fire & ~kind_ok;
    assign fault_ovf   = dec_fire & kind_ok & dec_call & depth_full;
    assign fault_unf   = dec_fire & kind_ok & dec_ret & depth_empty;
    assign any_fault   = fault_ill | fault_ovf | fault_unf;
    assign do_jmp      = dec_fire & kind_ok & dec_jmp;
    assign do_call     = dec_fire & kind_ok & dec_call & ~depth_full;
    assign do_ret      = dec_fire & kind_ok & dec_ret & ~depth_empty;
    assign fault_clear = (state_q == ST_FAULT) & clr_fault;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                    cnt_d   = INIT_LOAD;
                end
            end
            ST_INIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (any_fault) begin
                    state_d = ST_FAULT;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (clr_fault) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_d     = CMD_NONE;
        target_d  = '0;
        ack_d     = 1'b0;
        code_d    = code_q;
        depth_inc = 1'b0;
        depth_dec = 1'b0;
        depth_clr = fault_clear;
        if (irq_take) begin
            cmd_d     = CMD_CALL;
            target_d  = IRQ_VECTOR;
            ack_d     = 1'b1;
            depth_inc = 1'b1;
        end else if (do_jmp) begin
            cmd_d    = CMD_JMP;
            target_d = dec_target;
        end else if (do_call) begin
            cmd_d     = CMD_CALL;
            target_d  = dec_target;
            depth_inc = 1'b1;
        end else if (do_ret) begin
            cmd_d     = CMD_RET;
            depth_dec = 1'b1;
        end
        if (fault_ovf) begin
            code_d = FC_OVF;
        end else if (fault_unf) begin
            code_d = FC_UNF;
        end else if (fault_ill) begin
            code_d = FC_ILL;
        end
        if (fault_clear) begin
            code_d = FC_NONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q    <= CMD_NONE;
            target_q <= '0;
            code_q   <= FC_NONE;
            init_q   <= 1'b0;
            fault_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            cmd_q    <= cmd_d;
            target_q <= target_d;
            code_q   <= code_d;
            init_q   <= (state_d == ST_RUN);
            fault_q  <= (state_d == ST_FAULT);
            ack_q    <= ack_d;
        end
    end

    assign dec_ready    = ready_c;
    assign irq_ack      = ack_q;
    assign pc_init_flag = init_q;
    assign pc_jmp_flag  = (cmd_q == CMD_JMP);
    assign pc_call_flag = (cmd_q == CMD_CALL);
    assign pc_ret_flag  = (cmd_q == CMD_RET);
    assign pc_target    = target_q;
    assign stack_depth  = depth;
    assign fault        = fault_q;
    assign fault_code   = code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; interrupt checks follow PCSEQ_IRQ_EN.
module tb_pc_sequencer;

    localparam logic [7:0] I_START = 8'h80, I_HALT = 8'h40, I_CLR = 8'h20, I_VAL = 8'h10;
    localparam logic [7:0] I_JMP = 8'h08, I_CALL = 8'h04, I_RET = 8'h02, I_IRQ = 8'h01;
    localparam logic [2:0] E_JMP = 3'b001, E_CALL = 3'b010, E_RET = 3'b100;
    localparam logic [15:0] Z = 16'h0000;

    typedef struct {
        logic [7:0]  stim;
        logic [15:0] tgt;
        logic        ready;
        logic        init;
        logic [2:0]  cmd;
        logic [15:0] etgt;
        logic [10:0] depth;
        logic        fault;
        logic [1:0]  code;
        logic        ack;
        logic        inirq;
    } vec_t;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic        start = 1'b0, halt_req = 1'b0, clr_fault = 1'b0, dec_valid = 1'b0;
    logic        dec_jmp = 1'b0, dec_call = 1'b0, dec_ret = 1'b0, irq_req = 1'b0;
    logic [15:0] dec_target = '0;
    logic        dec_ready, irq_ack, pc_init_flag, pc_jmp_flag, pc_call_flag, pc_ret_flag;
    logic        in_irq, fault;
    logic [15:0] pc_target;
    logic [10:0] stack_depth;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    pc_sequencer #(
        .ADDR_W      (16),
        .STACK_DEPTH (1024),
        .DEPTH_W     (10),
        .INIT_CYCLES (4),
        .IRQ_VECTOR  (16'h0004)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .halt_req     (halt_req),
        .clr_fault    (clr_fault),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_jmp      (dec_jmp),
        .dec_call     (dec_call),
        .dec_ret      (dec_ret),
        .dec_target   (dec_target),
        .irq_req      (irq_req),
        .irq_ack      (irq_ack),
        .pc_init_flag (pc_init_flag),
        .pc_jmp_flag  (pc_jmp_flag),
        .pc_call_flag (pc_call_flag),
        .pc_ret_flag  (pc_ret_flag),
        .pc_target    (pc_target),
        .stack_depth  (stack_depth),
        .in_irq       (in_irq),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout required completion");
        $fatal(1);
    end

    function automatic vec_t mkv(input logic [7:0] stim, input logic [15:0] tgt,
                                 input logic ready, input logic init, input logic [2:0] cmd,
                                 input logic [15:0] etgt, input logic [10:0] depth,
                                 input logic flt, input logic [1:0] code,
                                 input logic ack, input logic inirq);
        vec_t v;
        v.stim = stim; v.tgt = tgt; v.ready = ready; v.init = init; v.cmd = cmd;
        v.etgt = etgt; v.depth = depth; v.fault = flt; v.code = code;
        v.ack = ack; v.inirq = inirq;
        return v;
    endfunction

    task automatic check(input string tag, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clock);
        {start, halt_req, clr_fault, dec_valid, dec_jmp, dec_call, dec_ret, irq_req} = v.stim;
        dec_target = v.tgt;
        #1 check(tag, "dec_ready", dec_ready, v.ready);
        @(posedge clock);
        #1;
        check(tag, "pc_init_flag", pc_init_flag, v.init);
        check(tag, "cmd{ret,call,jmp}", {pc_ret_flag, pc_call_flag, pc_jmp_flag}, v.cmd);
        check(tag, "pc_target", pc_target, v.etgt);
        check(tag, "stack_depth", stack_depth, v.depth);
        check(tag, "fault", fault, v.fault);
        check(tag, "fault_code", fault_code, v.code);
        check(tag, "irq_ack", irq_ack, v.ack);
        check(tag, "in_irq", in_irq, v.inirq);
    endtask

    task automatic check_zero(input string tag);
        check(tag, "dec_ready", dec_ready, 0);
        check(tag, "outputs", {irq_ack, pc_init_flag, pc_jmp_flag, pc_call_flag, pc_ret_flag,
                               in_irq, fault, fault_code}, 0);
        check(tag, "pc_target", pc_target, 0);
        check(tag, "stack_depth", stack_depth, 0);
    endtask

    task automatic restart(input string tag);
        reset_n = 1'b0;
        {start, halt_req, clr_fault, dec_valid, dec_jmp, dec_call, dec_ret, irq_req} = '0;
        dec_target = '0;
        #7;
        check_zero({tag, "_rst"});
        reset_n = 1'b1;
        apply(mkv(I_START, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0), {tag, "_start"});
        for (int k = 0; k < 3; k++) apply(mkv(0, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0), {tag, "_init"});
        apply(mkv(0, Z, 0, 1, 0, Z, 0, 0, 0, 0, 0), {tag, "_run"});
    endtask

    initial begin
        // Table: init timing, call/ret, jmp, halt/resume, underflow, illegal kinds.
        vecs.push_back(mkv(0,       Z, 0, 0, 0, Z, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(I_START, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mkv(0, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,       Z, 0, 1, 0, Z, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(I_VAL | I_CALL, 16'h0100, 1, 1, E_CALL, 16'h0100, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(I_VAL | I_RET,  Z,        1, 1, E_RET,  Z,        0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,              Z,        1, 1, 0,      Z,        0, 0, 0, 0, 0));
        vecs.push_back(mkv(I_VAL | I_JMP,  16'h0300, 1, 1, E_JMP,  16'h0300, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(I_VAL | I_CALL, 16'h0700, 1, 1, E_CALL, 16'h0700, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(I_HALT | I_VAL | I_JMP, 16'h0200, 0, 0, 0, Z, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(I_VAL | I_JMP,  16'h0200, 0, 0, 0,      Z,        1, 0, 0, 0, 0));
        vecs.push_back(mkv(I_START,        Z,        0, 1, 0,      Z,        1, 0, 0, 0, 0));
        vecs.push_back(mkv(I_VAL | I_RET,  Z,        1, 1, E_RET,  Z,        0, 0, 0, 0, 0));
        vecs.push_back(mkv(I_VAL | I_RET,  Z,        1, 0, 0,      Z,        0, 1, 2, 0, 0));
        vecs.push_back(mkv(I_START,        Z,        0, 0, 0,      Z,        0, 1, 2, 0, 0));
        vecs.push_back(mkv(I_CLR,          Z,        0, 0, 0,      Z,        0, 0, 0, 0, 0));
        vecs.push_back(mkv(I_START,        Z,        0, 0, 0,      Z,        0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mkv(0, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,              Z,        0, 1, 0,      Z,        0, 0, 0, 0, 0));
        vecs.push_back(mkv(I_VAL | I_JMP | I_CALL, 16'h0100, 1, 0, 0, Z, 0, 1, 3, 0, 0));
        vecs.push_back(mkv(I_CLR,          Z,        0, 0, 0,      Z,        0, 0, 0, 0, 0));
        vecs.push_back(mkv(I_START,        Z,        0, 0, 0,      Z,        0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mkv(0, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0,              Z,        0, 1, 0,      Z,        0, 0, 0, 0, 0));
        vecs.push_back(mkv(I_VAL,          Z,        1, 0, 0,      Z,        0, 1, 3, 0, 0));
        vecs.push_back(mkv(I_CLR,          Z,        0, 0, 0,      Z,        0, 0, 0, 0, 0));

        #7;
        check_zero("reset");
        reset_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        restart("irq");
`ifdef PCSEQ_IRQ_EN
        apply(mkv(I_IRQ | I_VAL | I_JMP,  16'h0200, 0, 1, E_CALL, 16'h0004, 1, 0, 0, 1, 1), "irq_entry");
        apply(mkv(I_IRQ | I_VAL | I_JMP,  16'h0200, 1, 1, E_JMP,  16'h0200, 1, 0, 0, 0, 1), "irq_jmp");
        apply(mkv(I_IRQ | I_VAL | I_CALL, 16'h0500, 1, 1, E_CALL, 16'h0500, 2, 0, 0, 0, 1), "irq_nest_call");
        apply(mkv(I_IRQ | I_VAL | I_RET,  Z,        1, 1, E_RET,  Z,        1, 0, 0, 0, 1), "irq_nest_ret");
        apply(mkv(I_IRQ | I_VAL | I_RET,  Z,        1, 1, E_RET,  Z,        0, 0, 0, 0, 0), "irq_exit");
        apply(mkv(I_IRQ,                  Z,        0, 1, E_CALL, 16'h0004, 1, 0, 0, 1, 1), "irq_reentry");
        apply(mkv(I_IRQ | I_VAL | I_RET,  Z,        1, 1, E_RET,  Z,        0, 0, 0, 0, 0), "irq_exit2");
`else
        apply(mkv(I_IRQ | I_VAL | I_JMP,  16'h0200, 1, 1, E_JMP,  16'h0200, 0, 0, 0, 0, 0), "irq_ignored_jmp");
        apply(mkv(I_IRQ,                  Z,        1, 1, 0,      Z,        0, 0, 0, 0, 0), "irq_ignored");
`endif

        restart("ovf");
        for (int i = 0; i < 1024; i++)
            apply(mkv(I_VAL | I_CALL, 16'(i), 1, 1, E_CALL, 16'(i), 11'(i + 1), 0, 0, 0, 0),
                  $sformatf("call%0d", i));
        apply(mkv(I_IRQ | I_VAL | I_JMP, 16'h0900, 1, 1, E_JMP, 16'h0900, 1024, 0, 0, 0, 0), "irq_full");
        apply(mkv(I_VAL | I_CALL, 16'h0a00, 1, 0, 0, Z, 1024, 1, 1, 0, 0), "ovf");
        apply(mkv(I_CLR, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0), "ovf_clr");

        restart("midrst");
        @(negedge clock);
        {start, halt_req, clr_fault, dec_valid, dec_jmp, dec_call, dec_ret, irq_req} = I_VAL | I_CALL;
        dec_target = 16'h0100;
        @(posedge clock);
        #1;
        check("midrst", "pulse", {pc_call_flag, pc_target}, {1'b1, 16'h0100});
        reset_n = 1'b0;
        #1;
        check_zero("midrst_abort");
        @(negedge clock);
        reset_n = 1'b1;
        apply(mkv(0, Z, 0, 0, 0, Z, 0, 0, 0, 0, 0), "midrst_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
